tmc_spi_responder: RTL and testbench

SPI responder (slave) that emulates the TMC5130 register interface at the far end of the `tmcspi` master: 40-bit datagrams, SPI mode 3, pipelined read data, and an internal 32-bit register file. It is used as the motor-driver stand-in in system simulation and FPGA loopback builds. It also reports every accepted write to fabric logic.

---
 rtl/tmc_spi_responder_if.sv | 11 +
 rtl/tmc_spi_responder.sv | 152 +++++++++++++++
 tb/tb_tmc_spi_responder.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmc_spi_responder_if.sv
// SPI pin bundle between a TMC-style SPI master and the responder.
// Mode 3: sclk idles high, data changes on the falling edge and is sampled on the rising edge.
interface tmc_spi_responder_if;
    logic sclk;
    logic csn;
    logic mosi;
    logic miso;

    modport master (output sclk, output csn, output mosi, input miso);
    modport slave  (input sclk, input csn, input mosi, output miso);
endinterface

// File: rtl/tmc_spi_responder.sv
// TMC5130-style SPI responder: 40-bit datagrams, pipelined reads, 2**ADDR_W x 32-bit register file.
// All SPI pins are oversampled in the clk domain; clk must run at least 8x sclk.
module tmc_spi_responder #(
    parameter int ADDR_W = 7
) (
    input  logic               clk,
    input  logic               resetn,
    tmc_spi_responder_if.slave spi,
    input  logic [7:0]         status,
    output logic               wr_valid,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [31:0]        wr_data,
    output logic               frame_err
);
    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_HIGH} state_t;

    state_t state, state_nxt;

    logic        sclk_p0, sclk_p1, sclk_p2;
    logic        csn_p0, csn_p1, csn_p2;
    logic        mosi_p0, mosi_p1;
    logic        sclk_rise, sclk_fall, csn_rise, csn_fall;

    logic [39:0] rx_sr;
    logic [38:0] tx_sr;
    logic [5:0]  bitcnt;
    logic [31:0] read_latch;
    logic        miso_q;
    logic [31:0] regs [2**ADDR_W];

    logic        start, rx_step, tx_step, commit;
    logic [6:0]  cmd_addr;
    logic [ADDR_W-1:0] reg_idx;
    logic        addr_ok, frame_ok, is_write, reg_we;

    // Stage p0/p1: synchronisers; p2: edge-detect history.
    // csn resets low so a frame already in progress at reset release is never joined.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_p0 <= 1'b1;
            sclk_p1 <= 1'b1;
            sclk_p2 <= 1'b1;
            csn_p0  <= 1'b0;
            csn_p1  <= 1'b0;
            csn_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= spi.sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            csn_p0  <= spi.csn;
            csn_p1  <= csn_p0;
            csn_p2  <= csn_p1;
            mosi_p0 <= spi.mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign csn_rise  = csn_p1 & ~csn_p2;
    assign csn_fall  = ~csn_p1 & csn_p2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= WAIT_HIGH;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HIGH: if (csn_p1) state_nxt = IDLE;
            IDLE: begin
                if (csn_fall)     state_nxt = ACTIVE;
                else if (!csn_p1) state_nxt = WAIT_HIGH;
            end
            ACTIVE:    if (csn_rise) state_nxt = IDLE;
            default:   state_nxt = WAIT_HIGH;
        endcase
    end

    // csn edges take priority over coincident sclk edges; a fall before any rise is ignored.
    always_comb begin
        start   = (state == IDLE) && csn_fall;
        commit  = (state == ACTIVE) && csn_rise;
        rx_step = (state == ACTIVE) && !csn_rise && sclk_rise;
        tx_step = (state == ACTIVE) && !csn_rise && sclk_fall && (bitcnt != 6'd0);
    end

    assign cmd_addr = rx_sr[38:32];
    assign reg_idx  = cmd_addr[ADDR_W-1:0];
    assign addr_ok  = (cmd_addr >> ADDR_W) == 7'd0;
    assign frame_ok = (bitcnt == 6'd40);
    assign is_write = rx_sr[39];
    assign reg_we   = commit && frame_ok && is_write && addr_ok;

    // Shift registers, pipelined read latch and fabric write report.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sr      <= '0;
            tx_sr      <= '0;
            bitcnt     <= '0;
            read_latch <= '0;
            miso_q     <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                bitcnt <= '0;
                tx_sr  <= {status[6:0], read_latch};
                miso_q <= status[7];
            end else if (state != ACTIVE || commit) begin
                miso_q <= 1'b0;
            end else if (tx_step) begin
                tx_sr  <= {tx_sr[37:0], 1'b0};
                miso_q <= tx_sr[38];
            end
            if (rx_step) begin
                rx_sr <= {rx_sr[38:0], mosi_p1};
                if (bitcnt != 6'd63) bitcnt <= bitcnt + 6'd1;
            end
            if (commit) begin
                if (!frame_ok) begin
                    frame_err <= 1'b1;
                end else if (is_write) begin
                    if (addr_ok) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= reg_idx;
                        wr_data  <= rx_sr[31:0];
                    end
                end else begin
                    read_latch <= addr_ok ? regs[reg_idx] : 32'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[reg_idx] <= rx_sr[31:0];
        end
    end

    assign spi.miso = miso_q;
endmodule

// File: tb/tb_tmc_spi_responder.sv
// Bench for tmc_spi_responder: bit-banged mode-3 master, reference register model,
// and scoreboard queues for expected responses and write reports.
module tb_tmc_spi_responder;
    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  status;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;

    tmc_spi_responder_if spi_bus();

    tmc_spi_responder #(.ADDR_W(7)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .spi       (spi_bus),
        .status    (status),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [39:0] resp_q[$];
    logic [31:0] m_regs [128];
    logic [31:0] m_latch;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          wr_seen = 0;
    int          ferr_seen = 0;

    // Write-report and frame-error monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && wr_valid === 1'b1) begin
            wr_seen++;
            tests_run++;
            if (wr_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    tests_failed++;
                    $display("FAIL wr_report: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
        if (resetn === 1'b1 && frame_err === 1'b1) ferr_seen++;
    end

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_regs[i] = '0;
        m_latch = '0;
    endtask

    task automatic spi_bit(input logic b, output logic s);
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = b;
        repeat (4) @(negedge clk);
        spi_bus.sclk = 1'b1;
        s = spi_bus.miso;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [39:0] word, input int nbits, input int gap,
                             output logic [39:0] got);
        logic s;
        got = '0;
        spi_bus.csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_bit((i < 40) ? word[39 - i] : 1'b0, s);
            got = {got[38:0], s};
        end
        spi_bus.csn = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Drives one frame; full frames have their response checked against the model.
    task automatic frame(input logic [39:0] word, input int nbits, input int gap,
                         output logic [39:0] got);
        logic [39:0] exp;
        resp_q.push_back({status, m_latch});
        if (nbits == 40) begin
            if (word[39]) begin
                m_regs[word[38:32]] = word[31:0];
                wr_q.push_back('{addr: word[38:32], data: word[31:0]});
            end else begin
                m_latch = m_regs[word[38:32]];
            end
        end
        spi_frame(word, nbits, gap, got);
        exp = resp_q.pop_front();
        if (nbits == 40) begin
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL miso_frame: got %h, expected %h (word %h)", got, exp, word);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        spi_bus.csn = 1'b1;
        spi_bus.sclk = 1'b1;
        spi_bus.mosi = 1'b0;
        status = 8'h00;
        model_reset();
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        tests_run += 5;
        if (spi_bus.miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b, expected 0", spi_bus.miso); end
        if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid: got %b, expected 0", wr_valid); end
        if (wr_addr !== 7'd0) begin tests_failed++; $display("FAIL reset_wr_addr: got %h, expected 0", wr_addr); end
        if (wr_data !== 32'd0) begin tests_failed++; $display("FAIL reset_wr_data: got %h, expected 0", wr_data); end
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    endtask

    task automatic test_write_read();
        logic [39:0] got;
        int w0;
        w0 = wr_seen;
        status = 8'h3C;
        frame(40'hA1_DEADBEEF, 40, 6, got);
        frame(40'h21_00000000, 40, 6, got);
        frame(40'h00_00000000, 40, 6, got);
        tests_run += 2;
        if (got !== {8'h3C, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL write_read_data: got %h, expected %h", got, {8'h3C, 32'hDEADBEEF});
        end
        if (wr_seen - w0 != 1) begin
            tests_failed++;
            $display("FAIL write_read_pulses: got %0d, expected 1", wr_seen - w0);
        end
    endtask

    task automatic test_pipelined_read();
        logic [39:0] got;
        status = 8'hC3;
        frame(40'h85_11111111, 40, 6, got);
        frame(40'h86_22222222, 40, 6, got);
        frame(40'h05_00000000, 40, 6, got);
        frame(40'h06_00000000, 40, 6, got);
        tests_run++;
        if (got[31:0] !== 32'h11111111) begin
            tests_failed++;
            $display("FAIL pipe_read_5: got %h, expected 11111111", got[31:0]);
        end
        frame(40'h00_00000000, 40, 6, got);
        tests_run++;
        if (got[31:0] !== 32'h22222222) begin
            tests_failed++;
            $display("FAIL pipe_read_6: got %h, expected 22222222", got[31:0]);
        end
    endtask

    task automatic test_status();
        logic [39:0] got;
        logic [39:0] words [3];
        words[0] = 40'h8A_0F0F0F0F;
        words[1] = 40'h0A_00000000;
        words[2] = 40'h21_00000000;
        status = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            frame(words[i], 40, 6, got);
            tests_run++;
            if (got[39:32] !== 8'h5A) begin
                tests_failed++;
                $display("FAIL status_byte[%0d]: got %h, expected 5a", i, got[39:32]);
            end
        end
    endtask

    task automatic test_short_long();
        logic [39:0] got;
        int w0, f0;
        status = 8'h81;
        frame(40'h90_CAFEF00D, 40, 6, got);
        w0 = wr_seen;
        f0 = ferr_seen;
        frame(40'h90_12345678, 39, 6, got);
        tests_run += 2;
        if (ferr_seen - f0 != 1) begin
            tests_failed++;
            $display("FAIL short_frame_err: got %0d pulses, expected 1", ferr_seen - f0);
        end
        if (wr_seen != w0) begin
            tests_failed++;
            $display("FAIL short_no_write: got %0d writes, expected 0", wr_seen - w0);
        end
        frame(40'h10_00000000, 40, 6, got);
        frame(40'h00_00000000, 40, 6, got);
        tests_run++;
        if (got[31:0] !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL short_reg_kept: got %h, expected cafef00d", got[31:0]);
        end
        f0 = ferr_seen;
        frame(40'h90_55555555, 41, 6, got);
        tests_run++;
        if (ferr_seen - f0 != 1) begin
            tests_failed++;
            $display("FAIL long_frame_err: got %0d pulses, expected 1", ferr_seen - f0);
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] word, got;
        logic s, any_hi;
        int w0, f0;
        word = 40'hB3_A5A5A5A5;
        status = 8'h17;
        spi_bus.csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 20; i++) spi_bit(word[39 - i], s);
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        w0 = wr_seen;
        f0 = ferr_seen;
        repeat (4) @(negedge clk);
        any_hi = spi_bus.miso;
        for (int i = 20; i < 40; i++) begin
            spi_bit(word[39 - i], s);
            any_hi = any_hi | s;
        end
        spi_bus.csn = 1'b1;
        repeat (8) @(negedge clk);
        tests_run += 4;
        if (any_hi !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_miso: got %b, expected 0", any_hi);
        end
        if (wr_seen != w0) begin
            tests_failed++;
            $display("FAIL reset_mid_commit: got %0d writes, expected 0", wr_seen - w0);
        end
        if (ferr_seen != f0) begin
            tests_failed++;
            $display("FAIL reset_mid_frame_err: got %0d pulses, expected 0", ferr_seen - f0);
        end
        if (wr_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_wr_data: got %h, expected 0", wr_data);
        end
        frame(40'hB3_0BADCAFE, 40, 6, got);
        frame(40'h33_00000000, 40, 6, got);
        frame(40'h00_00000000, 40, 6, got);
        tests_run++;
        if (wr_seen - w0 != 1) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: got %0d writes, expected 1", wr_seen - w0);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] got;
        int w0;
        status = 8'hE4;
        w0 = wr_seen;
        for (int i = 0; i < 4; i++) begin
            frame({1'b1, 7'(7'h40 + i), 32'h1000_0001 * (i + 3)}, 40, 4, got);
        end
        repeat (6) @(negedge clk);
        tests_run += 2;
        if (wr_seen - w0 != 4) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d, expected 4", wr_seen - w0);
        end
        if (wr_addr !== 7'h43) begin
            tests_failed++;
            $display("FAIL b2b_last_addr: got %h, expected 43", wr_addr);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_pipelined_read();
        test_status();
        test_short_long();
        test_reset_mid();
        test_back_to_back();
        repeat (10) @(negedge clk);
        tests_run++;
        if (wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wr_missing: got %0d outstanding, expected 0", wr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
